// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared opcode constants, EX control struct, bubble constant and stage states
package package_param;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_AND = 4'b0111;
    localparam logic [3:0] ALU_OR  = 4'b0110;

    typedef struct packed {
        logic       br_unsign;
        logic       op1_sel;
        logic       op2_sel;
        logic       branch_signal;
        logic       jmp_signal;
        logic       mem_to_reg;
        logic [3:0] alu_opcode;
        logic       mem_rden;
        logic       rd_wren;
        logic       mem_wren;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t CTRL_NOP = '0;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } id_ex_state_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-to-EX bundle; master drives the decode side, slave is the stage
interface id_ex_stage_if;
    import package_param::*;

    logic        i_id_valid;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic [31:0] i_imm;
    id_ex_ctrl_t i_ctrl;
    logic        i_flush;
    logic        i_hold;

    logic        o_ex_valid;
    logic [31:0] o_ex_pc;
    logic [31:0] o_ex_rs1_data;
    logic [31:0] o_ex_rs2_data;
    logic [31:0] o_ex_imm;
    logic [4:0]  o_ex_rd;
    logic [4:0]  o_ex_rs1;
    logic [4:0]  o_ex_rs2;
    id_ex_ctrl_t o_ex_ctrl;
    logic        o_stall;

    modport master (
        output i_id_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_imm, i_ctrl, i_flush, i_hold,
        input  o_ex_valid, o_ex_pc, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm,
               o_ex_rd, o_ex_rs1, o_ex_rs2, o_ex_ctrl, o_stall
    );

    modport slave (
        input  i_id_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_imm, i_ctrl, i_flush, i_hold,
        output o_ex_valid, o_ex_pc, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm,
               o_ex_rd, o_ex_rs1, o_ex_rs2, o_ex_ctrl, o_stall
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// rtl/id_ex_stage_hazard_detect.sv - combinational load-use detector between EX and ID
module hazard_detect (
    input  logic       ex_valid_i,
    input  logic       ex_mem_rden_i,
    input  logic [4:0] ex_rd_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    output logic       load_use_o
);
    // rs fields are compared for every opcode; a false match only costs one bubble
    assign load_use_o = ex_valid_i && ex_mem_rden_i && (ex_rd_i != 5'd0) && id_valid_i &&
                        ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble FSM; optional HAZARD_STATS_EN counters
module id_ex_stage
    import package_param::*;
(
    input  logic          i_clk,
    input  logic          i_reset,
    id_ex_stage_if.slave  bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]   o_stall_cnt,
    output logic [31:0]   o_flush_cnt
`endif
);

    id_ex_state_e state_q, state_d;
    logic         valid_q, valid_d;
    id_ex_ctrl_t  ctrl_q, ctrl_d;
    logic [31:0]  pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
    logic [4:0]   rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic         hz_load_use;
    logic         load_use;

    logic [4:0] id_rd, id_rs1, id_rs2;
    assign id_rd  = bus.i_instr[11:7];
    assign id_rs1 = bus.i_instr[19:15];
    assign id_rs2 = bus.i_instr[24:20];

    logic unused_instr_bits;
    assign unused_instr_bits = ^{bus.i_instr[31:25], bus.i_instr[14:12], bus.i_instr[6:0]};

    hazard_detect u_hazard_detect (
        .ex_valid_i    (valid_q),
        .ex_mem_rden_i (ctrl_q.mem_rden),
        .ex_rd_i       (rd_q),
        .id_valid_i    (bus.i_id_valid),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .load_use_o    (hz_load_use)
    );

    // BUBBLE already holds an invalid EX slot, but gating keeps the one-cycle limit explicit
    assign load_use    = hz_load_use && (state_q == ST_RUN);
    assign bus.o_stall = i_reset && !bus.i_flush && (bus.i_hold || load_use);

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        if (bus.i_flush || !bus.i_hold) begin
            pc_d       = bus.i_pc;
            rs1_data_d = bus.i_rs1_data;
            rs2_data_d = bus.i_rs2_data;
            imm_d      = bus.i_imm;
            rd_d       = id_rd;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
        end
        if (bus.i_flush) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NOP;
            state_d = ST_RUN;
        end else if (bus.i_hold) begin
            state_d = state_q;
        end else if (load_use) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NOP;
            state_d = ST_BUBBLE;
        end else begin
            valid_d = bus.i_id_valid;
            ctrl_d  = bus.i_id_valid ? bus.i_ctrl : CTRL_NOP;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_RUN;
            valid_q    <= 1'b0;
            ctrl_q     <= CTRL_NOP;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
        end
    end

    assign bus.o_ex_valid    = valid_q;
    assign bus.o_ex_ctrl     = ctrl_q;
    assign bus.o_ex_pc       = pc_q;
    assign bus.o_ex_rs1_data = rs1_data_q;
    assign bus.o_ex_rs2_data = rs2_data_q;
    assign bus.o_ex_imm      = imm_q;
    assign bus.o_ex_rd       = rd_q;
    assign bus.o_ex_rs1      = rs1_q;
    assign bus.o_ex_rs2      = rs2_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (bus.i_flush)
                flush_cnt_q <= flush_cnt_q + 32'd1;
            else if (!bus.i_hold && load_use)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed vector bench for id_ex_stage (HAZARD_STATS_EN checks when defined)
module tb_id_ex_stage;
    import package_param::*;

    localparam logic [31:0] LW_X5   = 32'h0000A283;
    localparam logic [31:0] ADD_X6  = 32'h00228333;
    localparam logic [31:0] LW_X0   = 32'h0000A003;
    localparam logic [31:0] ADD_X0  = 32'h00200333;
    localparam logic [31:0] ADDI_X3 = 32'h00700193;

    localparam id_ex_ctrl_t C_LW   = '{br_unsign:1'b0, op1_sel:1'b0, op2_sel:1'b1, branch_signal:1'b0,
                                       jmp_signal:1'b0, mem_to_reg:1'b1, alu_opcode:ALU_ADD,
                                       mem_rden:1'b1, rd_wren:1'b1, mem_wren:1'b0};
    localparam id_ex_ctrl_t C_ADD  = '{br_unsign:1'b0, op1_sel:1'b0, op2_sel:1'b0, branch_signal:1'b0,
                                       jmp_signal:1'b0, mem_to_reg:1'b0, alu_opcode:4'b0000,
                                       mem_rden:1'b0, rd_wren:1'b1, mem_wren:1'b0};
    localparam id_ex_ctrl_t C_ADDI = '{br_unsign:1'b0, op1_sel:1'b0, op2_sel:1'b1, branch_signal:1'b0,
                                       jmp_signal:1'b0, mem_to_reg:1'b0, alu_opcode:ALU_ADD,
                                       mem_rden:1'b0, rd_wren:1'b1, mem_wren:1'b0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if bus ();
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    id_ex_stage dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
`ifdef HAZARD_STATS_EN
        ,
        .o_stall_cnt (stall_cnt),
        .o_flush_cnt (flush_cnt)
`endif
    );

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        id_ex_ctrl_t ctrl;
        logic        flush;
        logic        hold;
        logic        exp_stall;
        logic        exp_valid;
        id_ex_ctrl_t exp_ctrl;
        logic        chk_data;
        logic [4:0]  exp_rd;
        logic [4:0]  exp_rs1;
        logic [4:0]  exp_rs2;
        logic [31:0] exp_pc;
        logic [31:0] exp_imm;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic valid, input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] imm, input id_ex_ctrl_t ctrl, input logic flush,
                           input logic hold, input logic exp_stall, input logic exp_valid,
                           input id_ex_ctrl_t exp_ctrl, input logic chk_data, input logic [4:0] exp_rd,
                           input logic [4:0] exp_rs1, input logic [4:0] exp_rs2,
                           input logic [31:0] exp_pc, input logic [31:0] exp_imm);
        vec_t v;
        v = '{valid, instr, pc, imm, ctrl, flush, hold, exp_stall, exp_valid, exp_ctrl,
              chk_data, exp_rd, exp_rs1, exp_rs2, exp_pc, exp_imm};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic valid, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] imm, input id_ex_ctrl_t ctrl, input logic flush,
                         input logic hold);
        bus.i_id_valid = valid;
        bus.i_instr    = instr;
        bus.i_pc       = pc;
        bus.i_rs1_data = pc ^ 32'hA5A5_A5A5;
        bus.i_rs2_data = ~pc;
        bus.i_imm      = imm;
        bus.i_ctrl     = ctrl;
        bus.i_flush    = flush;
        bus.i_hold     = hold;
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        drive(v.valid, v.instr, v.pc, v.imm, v.ctrl, v.flush, v.hold);
        #1;
        check($sformatf("v%0d stall", idx), {31'b0, bus.o_stall}, {31'b0, v.exp_stall});
        @(posedge clk);
        #1;
        check($sformatf("v%0d valid", idx), {31'b0, bus.o_ex_valid}, {31'b0, v.exp_valid});
        check($sformatf("v%0d ctrl", idx), {19'b0, bus.o_ex_ctrl}, {19'b0, v.exp_ctrl});
        if (v.chk_data) begin
            check($sformatf("v%0d rd", idx), {27'b0, bus.o_ex_rd}, {27'b0, v.exp_rd});
            check($sformatf("v%0d rs1", idx), {27'b0, bus.o_ex_rs1}, {27'b0, v.exp_rs1});
            check($sformatf("v%0d rs2", idx), {27'b0, bus.o_ex_rs2}, {27'b0, v.exp_rs2});
            check($sformatf("v%0d pc", idx), bus.o_ex_pc, v.exp_pc);
            check($sformatf("v%0d imm", idx), bus.o_ex_imm, v.exp_imm);
            check($sformatf("v%0d rs1_data", idx), bus.o_ex_rs1_data, v.exp_pc ^ 32'hA5A5_A5A5);
            check($sformatf("v%0d rs2_data", idx), bus.o_ex_rs2_data, ~v.exp_pc);
        end
    endtask

    initial begin
        //      vld instr    pc        imm  ctrl    fl hd  stall vld exp_ctrl  dat rd  rs1 rs2 exp_pc    exp_imm
        add_vec(1, LW_X5,   32'h100, 0,  C_LW,   0, 0,  0,    1,  C_LW,     1,  5,  1,  0,  32'h100, 0);
        add_vec(1, ADD_X6,  32'h104, 0,  C_ADD,  0, 0,  1,    0,  CTRL_NOP, 0,  0,  0,  0,  0,       0);
        add_vec(1, ADD_X6,  32'h104, 0,  C_ADD,  0, 0,  0,    1,  C_ADD,    1,  6,  5,  2,  32'h104, 0);
        add_vec(1, LW_X0,   32'h108, 0,  C_LW,   0, 0,  0,    1,  C_LW,     1,  0,  1,  0,  32'h108, 0);
        add_vec(1, ADD_X0,  32'h10C, 0,  C_ADD,  0, 0,  0,    1,  C_ADD,    1,  6,  0,  2,  32'h10C, 0);
        add_vec(1, LW_X5,   32'h110, 0,  C_LW,   0, 0,  0,    1,  C_LW,     1,  5,  1,  0,  32'h110, 0);
        add_vec(1, ADD_X6,  32'h114, 0,  C_ADD,  1, 0,  0,    0,  CTRL_NOP, 0,  0,  0,  0,  0,       0);
        add_vec(0, LW_X5,   32'h118, 0,  C_LW,   0, 0,  0,    0,  CTRL_NOP, 0,  0,  0,  0,  0,       0);
        add_vec(1, ADDI_X3, 32'h11C, 7,  C_ADDI, 0, 0,  0,    1,  C_ADDI,   1,  3,  0,  7,  32'h11C, 7);
        for (int k = 0; k < 3; k++)
            add_vec(1, LW_X5, 32'h200, 99, C_LW, 0, 1, 1,     1,  C_ADDI,   1,  3,  0,  7,  32'h11C, 7);
        add_vec(1, LW_X5,   32'h204, 0,  C_LW,   1, 1,  0,    0,  CTRL_NOP, 0,  0,  0,  0,  0,       0);
        add_vec(1, LW_X5,   32'h120, 0,  C_LW,   0, 0,  0,    1,  C_LW,     1,  5,  1,  0,  32'h120, 0);
        add_vec(1, ADD_X6,  32'h124, 0,  C_ADD,  0, 1,  1,    1,  C_LW,     1,  5,  1,  0,  32'h120, 0);
        add_vec(1, ADD_X6,  32'h124, 0,  C_ADD,  0, 0,  1,    0,  CTRL_NOP, 0,  0,  0,  0,  0,       0);
        add_vec(1, ADD_X6,  32'h124, 0,  C_ADD,  0, 0,  0,    1,  C_ADD,    1,  6,  5,  2,  32'h124, 0);

        drive(1, LW_X5, 32'h300, 5, C_LW, 0, 1);
        #2;
        check("reset valid", {31'b0, bus.o_ex_valid}, 32'd0);
        check("reset ctrl", {19'b0, bus.o_ex_ctrl}, 32'd0);
        check("reset pc", bus.o_ex_pc, 32'd0);
        check("reset rd", {27'b0, bus.o_ex_rd}, 32'd0);
        check("reset stall", {31'b0, bus.o_stall}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset held pc", bus.o_ex_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply(i, vecs[i]);

`ifdef HAZARD_STATS_EN
        check("stall_cnt", stall_cnt, 32'd2);
        check("flush_cnt", flush_cnt, 32'd2);
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        apply(100, vecs[0]);
        apply(101, vecs[1]);
        check("stall_cnt wrap", stall_cnt, 32'd0);
        check("flush_cnt after wrap", flush_cnt, 32'd2);
`endif

        apply(200, vecs[0]);
        apply(201, vecs[1]);
        check("pre-reset state", {31'b0, dut.state_q}, {31'b0, ST_BUBBLE});
        @(negedge clk);
        drive(1, ADD_X6, 32'h104, 0, C_ADD, 0, 1);
        rst_n = 1'b0;
        #1;
        check("midreset valid", {31'b0, bus.o_ex_valid}, 32'd0);
        check("midreset ctrl", {19'b0, bus.o_ex_ctrl}, 32'd0);
        check("midreset pc", bus.o_ex_pc, 32'd0);
        check("midreset imm", bus.o_ex_imm, 32'd0);
        check("midreset rs1", {27'b0, bus.o_ex_rs1}, 32'd0);
        check("midreset stall", {31'b0, bus.o_stall}, 32'd0);
        check("midreset state", {31'b0, dut.state_q}, {31'b0, ST_RUN});
`ifdef HAZARD_STATS_EN
        check("midreset stall_cnt", stall_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(300, vecs[0]);
        apply(301, vecs[1]);
        apply(302, vecs[2]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
